// File: rtl/renas_package.sv
// Shared types exchanged between fetch, execute and the branch predictor.
package renas_package;
  import renas_user_parameters::*;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_type;

  // Prediction presented to fetch; GBP_predict and GBHR travel down the pipe
  // and come back in br_update_type when the branch resolves.
  typedef struct packed {
    logic                             branch_take;
    logic [1:0]                       GBP_predict;
    logic [GSHARE_HISTORY_LENGTH-1:0] GBHR;
  } br_check_type;

  // Resolution information from execute. GBP_predict_update is the already
  // trained counter value; the predictor stores it verbatim.
  typedef struct packed {
    logic                             update;
    logic                             wrong;
    logic                             actual;
    logic [1:0]                       GBP_predict_update;
    logic [GSHARE_HISTORY_LENGTH-1:0] GBHR_old;
  } br_update_type;

  // Weakly-not-taken starting value for every PHT counter.
  localparam logic [1:0] PHT_INIT_VALUE = 2'b01;
endpackage

// File: rtl/renas_user_parameters.sv
// User-tunable sizing for the RENAS branch predictor.
package renas_user_parameters;
  localparam int GSHARE_HISTORY_LENGTH = 8;   // PHT index width / global history length
  localparam int BTB_INDEX_LENGTH      = 4;   // BTB index width
  localparam int PC_LENGTH             = 32;  // program counter width
endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: combinational read, one synchronous write port and a
// per-entry valid clear used by the initialisation sweep.
module bp_btb #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [PC_W-1:0]  rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);
  localparam int ENTRIES = 1 << IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];

  // Contents are defined only by the clear sweep and training writes; a
  // write to the entry being cleared wins, though the two never overlap.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end
    if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  // Read returns the stored (pre-write) value; no bypass of same-cycle writes.
  always_comb begin
    rd_valid  = valid_q[rd_idx];
    rd_tag    = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
  end
endmodule

// File: rtl/branch_predictor_unit.sv
// Gshare direction predictor with a direct-mapped BTB. After reset an INIT
// sweep sets every PHT counter to weakly-not-taken and invalidates the BTB.
module branch_predictor_unit
  import renas_user_parameters::*;
  import renas_package::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_LENGTH-1:0] pc_if,
  input  logic                 fetch_valid,
  input  logic                 stall_if,
  output br_check_type         br_check_if,
  output logic [PC_LENGTH-1:0] predicted_pc,
  output logic                 bp_ready,
  input  br_update_type        br_update_ex,
  input  logic [PC_LENGTH-1:0] pc_ex,
  input  logic [PC_LENGTH-1:0] actual_pc
);
  localparam int GHL         = GSHARE_HISTORY_LENGTH;
  localparam int BIL         = BTB_INDEX_LENGTH;
  localparam int PHT_ENTRIES = 1 << GHL;
  localparam int BTB_ENTRIES = 1 << BIL;
  localparam int TAG_W       = PC_LENGTH - BIL - 2;
  localparam logic [GHL-1:0] IDX_LAST = '1;

  bp_state_type   state_q, state_d;
  logic [GHL-1:0] idx_q, idx_d;
  logic [GHL-1:0] gbhr_q, gbhr_d;
  logic [1:0]     pht_q [PHT_ENTRIES];

  logic           pht_we;
  logic [GHL-1:0] pht_waddr;
  logic [1:0]     pht_wdata;
  logic           btb_clr_en;

  logic             in_run;
  logic [GHL-1:0]   fetch_idx;
  logic             btb_rd_valid;
  logic [TAG_W-1:0] btb_rd_tag;
  logic [PC_LENGTH-1:0] btb_rd_target;
  logic             hit;
  logic             take;
  logic             train_en;
  logic             unused_pc_ex_low;

  assign unused_pc_ex_low = ^pc_ex[1:0];

  // Lookups are suppressed while reset is asserted so outputs look like INIT.
  assign in_run    = (state_q == RUN) && !rst;
  assign fetch_idx = gbhr_q ^ pc_if[GHL+1:2];
  assign train_en  = in_run && br_update_ex.update;

  bp_btb #(
    .IDX_W (BIL),
    .TAG_W (TAG_W),
    .PC_W  (PC_LENGTH)
  ) u_btb (
    .clk       (clk),
    .rd_idx    (pc_if[BIL+1:2]),
    .rd_valid  (btb_rd_valid),
    .rd_tag    (btb_rd_tag),
    .rd_target (btb_rd_target),
    .wr_en     (train_en && br_update_ex.actual),
    .wr_idx    (pc_ex[BIL+1:2]),
    .wr_tag    (pc_ex[PC_LENGTH-1:BIL+2]),
    .wr_target (actual_pc),
    .clr_en    (btb_clr_en),
    .clr_idx   (idx_q[BIL-1:0])
  );

  // Fetch-side prediction: PHT direction gated by a valid, tag-matching BTB hit.
  always_comb begin
    br_check_if             = '0;
    br_check_if.GBP_predict = PHT_INIT_VALUE;
    br_check_if.GBHR        = gbhr_q;
    hit                     = in_run && btb_rd_valid &&
                              (btb_rd_tag == pc_if[PC_LENGTH-1:BIL+2]);
    if (in_run) begin
      br_check_if.GBP_predict = pht_q[fetch_idx];
    end
    take                    = hit && br_check_if.GBP_predict[1];
    br_check_if.branch_take = take;
    predicted_pc            = take ? btb_rd_target : (pc_if + PC_LENGTH'(4));
    bp_ready                = (state_q == RUN) && !rst;
  end

  // Init sweep sequencing and selection of the single PHT write port.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pht_we     = 1'b0;
    pht_waddr  = br_update_ex.GBHR_old ^ pc_ex[GHL+1:2];
    pht_wdata  = br_update_ex.GBP_predict_update;
    btb_clr_en = 1'b0;
    case (state_q)
      INIT: begin
        pht_we     = 1'b1;
        pht_waddr  = idx_q;
        pht_wdata  = PHT_INIT_VALUE;
        btb_clr_en = int'(idx_q) < BTB_ENTRIES;
        idx_d      = idx_q + GHL'(1);
        if (idx_q == IDX_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pht_we = train_en;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Global history: misprediction recovery has priority over speculative shift.
  always_comb begin
    gbhr_d = gbhr_q;
    if (in_run) begin
      if (br_update_ex.update && br_update_ex.wrong) begin
        gbhr_d = {br_update_ex.GBHR_old[GHL-2:0], br_update_ex.actual};
      end else if (fetch_valid && !stall_if && hit) begin
        gbhr_d = {gbhr_q[GHL-2:0], take};
      end
    end
  end

  // Control state and history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      gbhr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gbhr_q  <= gbhr_d;
    end
  end

  // PHT storage, written only through the init sweep or training port.
  always_ff @(posedge clk) begin
    if (pht_we) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Randomised + directed bench for branch_predictor_unit with a queue-based
// scoreboard fed by a behavioural reference model.
module tb_branch_predictor_unit;
  import renas_user_parameters::*;
  import renas_package::*;

  localparam int GHL   = GSHARE_HISTORY_LENGTH;
  localparam int BIL   = BTB_INDEX_LENGTH;
  localparam int PW    = PC_LENGTH;
  localparam int PHT_N = 1 << GHL;
  localparam int BTB_N = 1 << BIL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [PW-1:0] pc_if = '0;
  logic          fetch_valid = 1'b0;
  logic          stall_if = 1'b0;
  br_check_type  br_check_if;
  logic [PW-1:0] predicted_pc;
  logic          bp_ready;
  br_update_type br_update_ex = '0;
  logic [PW-1:0] pc_ex = '0;
  logic [PW-1:0] actual_pc = '0;

  branch_predictor_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_if        (pc_if),
    .fetch_valid  (fetch_valid),
    .stall_if     (stall_if),
    .br_check_if  (br_check_if),
    .predicted_pc (predicted_pc),
    .bp_ready     (bp_ready),
    .br_update_ex (br_update_ex),
    .pc_ex        (pc_ex),
    .actual_pc    (actual_pc)
  );

  typedef struct {
    int            id;
    bit            take;
    bit [1:0]      gbp;
    bit [GHL-1:0]  gbhr;
    bit            gbhr_known;
    bit [PW-1:0]   pc;
    bit            ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  bit   stim_done = 1'b0;

  // Reference model: plain arrays indexed by address arithmetic.
  bit [1:0]     m_pht   [PHT_N];
  bit           m_bv    [BTB_N];
  bit [PW-1:0]  m_bpc   [BTB_N];   // address of the branch that trained the slot
  bit [PW-1:0]  m_btgt  [BTB_N];
  bit           m_run = 1'b0;
  int           m_cnt = 0;
  int           m_gbhr = 0;
  bit           m_known = 1'b0;

  task automatic step(input bit r, input bit [PW-1:0] pc, input bit fv, input bit st,
                      input bit upd, input bit wr, input bit act, input bit [1:0] gpu,
                      input bit [GHL-1:0] gold, input bit [PW-1:0] pcx, input bit [PW-1:0] apc);
    exp_t e;
    int bi, fi, ui, bx;
    bit look, hit;
    @(negedge clk);
    #1;
    rst = r; pc_if = pc; fetch_valid = fv; stall_if = st;
    br_update_ex.update = upd; br_update_ex.wrong = wr; br_update_ex.actual = act;
    br_update_ex.GBP_predict_update = gpu; br_update_ex.GBHR_old = gold;
    pc_ex = pcx; actual_pc = apc;

    bi   = int'((pc >> 2) % BTB_N);
    fi   = (m_gbhr ^ int'((pc >> 2) % PHT_N)) % PHT_N;
    look = m_run && !r;
    hit  = look && m_bv[bi] && ((m_bpc[bi] >> (BIL + 2)) == (pc >> (BIL + 2)));
    e.id         = txn;
    e.gbp        = look ? m_pht[fi] : 2'd1;
    e.take       = hit && (e.gbp >= 2);
    e.pc         = e.take ? m_btgt[bi] : pc + 4;
    e.gbhr       = GHL'(m_gbhr);
    e.gbhr_known = m_known;
    e.ready      = m_run && !r;
    exp_q.push_back(e);
    txn++;

    if (r) begin
      m_run = 1'b0; m_cnt = 0; m_gbhr = 0; m_known = 1'b1;
    end else if (!m_run) begin
      m_pht[m_cnt] = 2'd1;
      if (m_cnt < BTB_N) m_bv[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == PHT_N) m_run = 1'b1;
    end else begin
      if (upd) begin
        ui = (int'(gold) ^ int'((pcx >> 2) % PHT_N)) % PHT_N;
        m_pht[ui] = gpu;
        if (act) begin
          bx = int'((pcx >> 2) % BTB_N);
          m_bv[bx] = 1'b1; m_bpc[bx] = pcx; m_btgt[bx] = apc;
        end
      end
      if (upd && wr) m_gbhr = (int'(gold) * 2 + int'(act)) % PHT_N;
      else if (fv && !st && hit) m_gbhr = (m_gbhr * 2 + int'(e.take)) % PHT_N;
    end
  endtask

  task automatic fetch(input bit [PW-1:0] pc, input bit fv, input bit st);
    step(1'b0, pc, fv, st, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
  endtask

  task automatic train(input bit [PW-1:0] pc, input bit fv, input bit wr, input bit act,
                       input bit [1:0] gpu, input bit [GHL-1:0] gold,
                       input bit [PW-1:0] pcx, input bit [PW-1:0] apc);
    step(1'b0, pc, fv, 1'b0, 1'b1, wr, act, gpu, gold, pcx, apc);
  endtask

  task automatic rand_step(input bit allow_upd);
    bit [PW-1:0] pc, pcx, apc;
    pc  = PW'($urandom_range(0, 255)) << 2;
    pcx = PW'($urandom_range(0, 255)) << 2;
    apc = PW'($urandom) & ~PW'(3);
    step(1'b0, pc, 1'($urandom), 1'($urandom_range(0, 3) == 0),
         allow_upd && ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
         2'($urandom), GHL'($urandom), pcx, apc);
  endtask

  task automatic cmp(input string name, input int id, input logic [PW-1:0] act_v,
                     input logic [PW-1:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", id, name, act_v, exp_v);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle once the
  // stimulus for this cycle has been applied and its expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("branch_take", e.id, PW'(br_check_if.branch_take), PW'(e.take));
        cmp("GBP_predict", e.id, PW'(br_check_if.GBP_predict), PW'(e.gbp));
        if (e.gbhr_known) cmp("GBHR", e.id, PW'(br_check_if.GBHR), PW'(e.gbhr));
        cmp("predicted_pc", e.id, predicted_pc, e.pc);
        cmp("bp_ready", e.id, PW'(bp_ready), PW'(e.ready));
        $display("txn %0d pc_if=%h take=%0b gbp=%0d gbhr=%h pred=%h ready=%0b",
                 e.id, pc_if, br_check_if.branch_take, br_check_if.GBP_predict,
                 br_check_if.GBHR, predicted_pc, bp_ready);
      end
    end
  end

  initial begin
    // Reset, then the full init sweep with noisy (ignored) updates.
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
    for (int i = 0; i < PHT_N; i++) rand_step(1'b1);
    fetch(32'h100, 1'b1, 1'b0);                       // first RUN cycle: cold miss

    // Cold miss then train with recovery.
    train(32'h000, 1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 32'h100, 32'h200);
    fetch(32'h100, 1'b0, 1'b0);
    // Make the entry used under the current history strongly taken.
    train(32'h000, 1'b0, 1'b0, 1'b1, 2'b11, 8'h01, 32'h100, 32'h200);
    fetch(32'h100, 1'b1, 1'b0);                       // speculative shift
    train(32'h000, 1'b0, 1'b0, 1'b1, 2'b11, 8'h03, 32'h100, 32'h200);
    fetch(32'h100, 1'b1, 1'b1);                       // stalled: history holds
    fetch(32'h100, 1'b0, 1'b0);
    // Collision: speculative shift and recovery in the same cycle.
    train(32'h100, 1'b1, 1'b1, 1'b0, 2'b00, 8'h55, 32'h300, 32'h400);
    fetch(32'h100, 1'b0, 1'b0);
    // Alias: 0x140 replaces 0x100 in the same BTB slot.
    train(32'h000, 1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 32'h140, 32'h500);
    fetch(32'h100, 1'b1, 1'b0);
    fetch(32'h140, 1'b0, 1'b0);
    // Same-cycle read/write of one BTB slot returns the old contents.
    train(32'h140, 1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 32'h140, 32'h600);
    fetch(32'h140, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) rand_step(1'b1);
    train(32'h000, 1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 32'h140, 32'h700);

    // Reset mid-RUN, re-sweep, trained entry must be gone.
    step(1'b1, 32'h140, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'hff, 32'h140, 32'h800);
    fetch(32'h140, 1'b1, 1'b0);
    // Reset again mid-INIT.
    for (int i = 0; i < 20; i++) rand_step(1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
    for (int i = 0; i < PHT_N; i++) rand_step(1'b1);
    fetch(32'h140, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++) rand_step(1'b1);

    @(negedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
    end
  end
endmodule
